multi_port_fifo: RTL
====================

Name: multi_port_fifo

Overview:
- Parametrised synchronous FIFO with up to W_PORTS enqueues and R_PORTS dequeues per cycle, plus atomic pointer restore for misprediction recovery.
- Serves as free-register list, ROB-tag pool and multi-issue queue in the Tomasulo core.
- Capacity bookkeeping uses (n+1)-bit pointers.
- Read data is combinational, look-ahead over the next R_PORTS entries.

Parameters:
- DEPTH, 32, number of entries; power of 2, ≥ 2.
- WIDTH, 32, data width per entry.
- W_PORTS, 2, maximum writes per cycle; 1..4, ≤ DEPTH.
- R_PORTS, 2, maximum reads per cycle; 1..4, ≤ DEPTH.
- RESET_MODE, 0, memory contents at reset: 0 = untouched (X); 1 = all 0; 2 = all 1; 3 = pool mode.
- INIT_BASE, 32, first value loaded in pool mode (mem[i] = INIT_BASE + i).
- PTR_WIDTH (localparam), log2(DEPTH)+1, pointer width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- w_cnt  in  log2(W_PORTS)+1  number of entries to enqueue this cycle.
- din  in  W_PORTS*WIDTH  slot k at bits [k*WIDTH +: WIDTH]; slot 0 is enqueued first.
- r_cnt  in  log2(R_PORTS)+1  number of entries to dequeue this cycle.
- dout  out  R_PORTS*WIDTH  slot k = mem[(r_ptr+k) mod DEPTH].
- dout_vld  out  R_PORTS  bit k = (count > k).
- count  out  PTR_WIDTH  occupied entries, 0..DEPTH.
- space  out  PTR_WIDTH  DEPTH − count.
- full, empty  out  1 each  count==DEPTH, count==0.
- w_ptr, r_ptr  out  PTR_WIDTH each  current pointers, for checkpointing.
- restore_en  in  1  load both pointers this cycle.
- restore_w_ptr, restore_r_ptr  in  PTR_WIDTH each  restore values.
- w_fail, r_fail, restore_fail  out  1 each  combinational rejection flags.

Behaviour:
- Reset (sync, active-high; clock clk):
  - Modes 0–2: r_ptr=0, w_ptr=0, so count=0, empty=1, full=0.
  - Mode 3: w_ptr=DEPTH (MSB set, low bits 0), r_ptr=0, so count=DEPTH, full=1, space=0; mem[i]=INIT_BASE+i truncated to WIDTH.
  - Reset overrides every other input.
- Pointers: increment modulo 2*DEPTH (natural PTR_WIDTH wrap). Memory index = low log2(DEPTH) bits.
- Occupancy: count = w_ptr − r_ptr (PTR_WIDTH arithmetic). All flags derive from the registered pointers only.
- Write acceptance: w_ok = (w_cnt ≤ space) && (w_cnt ≤ W_PORTS) && !restore_en.
  - When w_ok: slots 0..w_cnt−1 are written to mem[w_ptr+k] at the edge, and w_ptr += w_cnt.
  - All-or-nothing: a rejected request writes nothing.
- Read acceptance: r_ok = (r_cnt ≤ count) && (r_cnt ≤ R_PORTS) && !restore_en.
  - When r_ok: r_ptr += r_cnt.
  - dout is valid in the same cycle; there is no read latency.
- Bypass: no same-cycle write-to-read bypass. An entry written at edge t is readable from cycle t+1.
- Space: free slots from same-cycle reads are not visible to writes until the next cycle. Simultaneous read and write therefore never conflict on a memory index.
- Fail flags:
  - w_fail = (w_cnt≠0) && !w_ok.
  - r_fail = (r_cnt≠0) && !r_ok.
  - A zero count never fails.
- Restore:
  - Has priority over read and write.
  - restore_fail = restore_en && ((restore_w_ptr − restore_r_ptr) > DEPTH).
  - On fail, the pointers are unchanged; otherwise both are loaded at the edge. Memory contents are never modified by restore.
  - Any nonzero w_cnt or r_cnt during restore_en asserts the corresponding fail flag.
- Out-of-range counts (w_cnt>W_PORTS, r_cnt>R_PORTS) are rejected via the fail flags.
- No state machine; state is the pointer pair plus the memory array.

Decomposition:
- Shared package fifo_pkg holds:
  - RESET_MODE encodings: RST_NONE=0, RST_ZERO=1, RST_ONE=2, RST_POOL=3.
  - A clog2 function for deriving PTR_WIDTH and count widths.
- One natural sub-module: fifo_ptr_ctrl, containing the pointer registers, count/space/full/empty, acceptance and fail logic, and restore.
- The memory array and read/write slot muxing stay in the top level, selected per RESET_MODE via generate.

Test Plan:
- Basic fill/drain (DEPTH=8, W_PORTS=R_PORTS=2, mode 0): four cycles of w_cnt=2 with din pairs {1,2},{3,4},{5,6},{7,8} → full=1, count=8. Next w_cnt=1 → w_fail=1, w_ptr stays 8. Then r_cnt=2 ×4 → dout pairs in order 1..8, empty=1. r_cnt=1 → r_fail=1.
- Partial acceptance and wrap: fill to count=7, w_cnt=2 → w_fail=1, count stays 7. r_cnt=2 then w_cnt=2 → pointers wrap past index 7, and data order is preserved across the wrap over 20 cycles.
- Simultaneous read/write at count=1: r_cnt=1, w_cnt=2 → count=2 next cycle; dout slot 0 equals the first newly written value.
- Pool reset (mode 3, INIT_BASE=32, DEPTH=8): after reset, count=8, dout={32,33}. r_cnt=2 → dout={34,35}, space=2.
- Restore: snapshot at r_ptr=2, w_ptr=6; advance to r_ptr=5, w_ptr=9; restore_en with w_cnt=1 → restore_fail=0, w_fail=1, pointers become 2/6, count=4. Restore with w=12, r=2 → restore_fail=1, pointers unchanged.
- Reset mid-operation: reset asserted together with w_cnt=2 and r_cnt=1 → next cycle count=0 (mode 0), w_fail=r_fail=0 after release, dout_vld=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-port FIFO: memory reset modes and
// a constant clog2 for deriving pointer and count widths.
package fifo_pkg;

  localparam int unsigned RST_NONE = 0;
  localparam int unsigned RST_ZERO = 1;
  localparam int unsigned RST_ONE  = 2;
  localparam int unsigned RST_POOL = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer pair, occupancy flags, per-cycle acceptance and restore for the
// multi-port FIFO. Memory is handled by the parent.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned W_PORTS   = 2,
  parameter int unsigned R_PORTS   = 2,
  parameter bit          POOL_MODE = 1'b0,
  localparam int unsigned PTR_WIDTH = clog2(DEPTH) + 1,
  localparam int unsigned WCW       = clog2(W_PORTS) + 1,
  localparam int unsigned RCW       = clog2(R_PORTS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WCW-1:0]       w_cnt,
  input  logic [RCW-1:0]       r_cnt,
  input  logic                 restore_en,
  input  logic [PTR_WIDTH-1:0] restore_w_ptr,
  input  logic [PTR_WIDTH-1:0] restore_r_ptr,
  output logic [PTR_WIDTH-1:0] w_ptr,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic [PTR_WIDTH-1:0] count,
  output logic [PTR_WIDTH-1:0] space,
  output logic                 full,
  output logic                 empty,
  output logic                 w_ok,
  output logic                 w_fail,
  output logic                 r_fail,
  output logic                 restore_fail
);

  localparam logic [PTR_WIDTH-1:0] PtrDepth = PTR_WIDTH'(DEPTH);
  // Pool mode starts full: every entry is a free token.
  localparam logic [PTR_WIDTH-1:0] WPtrRst  = POOL_MODE ? PtrDepth : {PTR_WIDTH{1'b0}};
  localparam logic [WCW-1:0]       WMax     = WCW'(W_PORTS);
  localparam logic [RCW-1:0]       RMax     = RCW'(R_PORTS);

  logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_WIDTH-1:0] restore_diff;
  logic                 r_ok;

  assign w_ptr        = w_ptr_q;
  assign r_ptr        = r_ptr_q;
  assign count        = w_ptr_q - r_ptr_q;
  assign space        = PtrDepth - count;
  assign full         = (count == PtrDepth);
  assign empty        = (count == '0);
  assign restore_diff = restore_w_ptr - restore_r_ptr;

  always_comb begin
    w_ok         = (PTR_WIDTH'(w_cnt) <= space) && (w_cnt <= WMax) && !restore_en;
    r_ok         = (PTR_WIDTH'(r_cnt) <= count) && (r_cnt <= RMax) && !restore_en;
    w_fail       = (w_cnt != '0) && !w_ok;
    r_fail       = (r_cnt != '0) && !r_ok;
    restore_fail = restore_en && (restore_diff > PtrDepth);

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (restore_en) begin
      if (!restore_fail) begin
        w_ptr_d = restore_w_ptr;
        r_ptr_d = restore_r_ptr;
      end
    end else begin
      if (w_ok) w_ptr_d = w_ptr_q + PTR_WIDTH'(w_cnt);
      if (r_ok) r_ptr_d = r_ptr_q + PTR_WIDTH'(r_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= WPtrRst;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-port FIFO: up to W_PORTS writes and R_PORTS look-ahead reads per cycle,
// with atomic pointer restore. Memory array and slot muxing live here.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned W_PORTS    = 2,
  parameter int unsigned R_PORTS    = 2,
  parameter int unsigned RESET_MODE = 0,
  parameter int unsigned INIT_BASE  = 32,
  localparam int unsigned PTR_WIDTH = clog2(DEPTH) + 1,
  localparam int unsigned WCW       = clog2(W_PORTS) + 1,
  localparam int unsigned RCW       = clog2(R_PORTS) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WCW-1:0]             w_cnt,
  input  logic [W_PORTS*WIDTH-1:0]   din,
  input  logic [RCW-1:0]             r_cnt,
  output logic [R_PORTS*WIDTH-1:0]   dout,
  output logic [R_PORTS-1:0]         dout_vld,
  output logic [PTR_WIDTH-1:0]       count,
  output logic [PTR_WIDTH-1:0]       space,
  output logic                       full,
  output logic                       empty,
  output logic [PTR_WIDTH-1:0]       w_ptr,
  output logic [PTR_WIDTH-1:0]       r_ptr,
  input  logic                       restore_en,
  input  logic [PTR_WIDTH-1:0]       restore_w_ptr,
  input  logic [PTR_WIDTH-1:0]       restore_r_ptr,
  output logic                       w_fail,
  output logic                       r_fail,
  output logic                       restore_fail
);

  localparam int unsigned AW = PTR_WIDTH - 1;

  logic             w_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .W_PORTS   (W_PORTS),
    .R_PORTS   (R_PORTS),
    .POOL_MODE (RESET_MODE == RST_POOL)
  ) u_ptr_ctrl (
    .clk           (clk),
    .reset         (reset),
    .w_cnt         (w_cnt),
    .r_cnt         (r_cnt),
    .restore_en    (restore_en),
    .restore_w_ptr (restore_w_ptr),
    .restore_r_ptr (restore_r_ptr),
    .w_ptr         (w_ptr),
    .r_ptr         (r_ptr),
    .count         (count),
    .space         (space),
    .full          (full),
    .empty         (empty),
    .w_ok          (w_ok),
    .w_fail        (w_fail),
    .r_fail        (r_fail),
    .restore_fail  (restore_fail)
  );

  // Writes land in slots w_ptr..w_ptr+w_cnt-1; acceptance already guarantees room.
  always_comb begin
    mem_d = mem_q;
    if (w_ok) begin
      for (int k = 0; k < int'(W_PORTS); k++) begin
        if (k < int'(w_cnt)) begin
          mem_d[w_ptr[AW-1:0] + AW'(k)] = din[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < int'(R_PORTS); k++) begin : g_rd
    logic [AW-1:0] rd_idx;
    assign rd_idx                  = r_ptr[AW-1:0] + AW'(k);
    assign dout[k*WIDTH +: WIDTH]  = mem_q[rd_idx];
    assign dout_vld[k]             = (count > PTR_WIDTH'(k));
  end

  if (RESET_MODE == RST_NONE) begin : g_mem_noreset
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end
  end else begin : g_mem_reset
    function automatic logic [WIDTH-1:0] rst_word(input int unsigned i);
      unique case (RESET_MODE)
        RST_ZERO: return '0;
        RST_ONE:  return '1;
        default:  return WIDTH'(INIT_BASE + i);
      endcase
    endfunction

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[i] <= rst_word(i);
        end
      end else begin
        mem_q <= mem_d;
      end
    end
  end

endmodule
